// File: rtl/aes_sbox_arbiter.sv
// Round-robin arbiter sharing one 32-bit forward S-box word lookup between AES requesters.
// Define AES_SBOX_ARB_PIPE_EN to register the response path (lookup latency 1); default is combinational.
module aes_sbox_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_sboxw,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [31:0]            sboxw,
  input  logic [31:0]            new_sboxw,
  output logic [31:0]            rsp_sboxw,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic                   busy
);

  localparam int              IW        = $clog2(NUM_REQ);
  localparam logic [0:0]      ST_IDLE   = 1'b0;
  localparam logic [0:0]      ST_GRANT  = 1'b1;
  localparam logic [7:0]      HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_REQ - 1);

  logic [0:0]          r_state;
  logic [0:0]          w_state_next;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       w_owner_next;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       w_rr_ptr_next;
  logic [IW-1:0]       w_owner_inc;
  logic [7:0]          r_hold_ctr;
  logic [7:0]          w_hold_ctr_next;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  w_gnt_next;
  logic [NUM_REQ-1:0]  w_others;
  logic                w_owner_req;
  logic                w_hold_last;
  logic                w_any_other;
  logic [IW:0]         w_pick_idle;
  logic [IW:0]         w_pick_next;
  logic [31:0]         w_words [NUM_REQ];

  // First set bit of v scanning start, start+1, ... modulo NUM_REQ; MSB flags a hit.
  function automatic logic [IW:0] f_pick(input logic [NUM_REQ-1:0] v,
                                         input logic [IW-1:0]      start);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(start) + k) % NUM_REQ);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IW-1:0] idx);
    logic [NUM_REQ-1:0] res;
    res      = '0;
    res[idx] = 1'b1;
    return res;
  endfunction

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
    assign w_words[gi] = req_sboxw[32*gi +: 32];
  end

  // r_gnt is one-hot on the owner while granted, so masking it leaves the competitors.
  assign w_others    = req & ~r_gnt;
  assign w_any_other = |w_others;
  assign w_owner_req = |(req & r_gnt);
  assign w_hold_last = (r_hold_ctr == HOLD_LAST);
  assign w_owner_inc = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
  assign w_pick_idle = f_pick(req, r_rr_ptr);
  assign w_pick_next = f_pick(w_others, w_owner_inc);

  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
    w_rr_ptr_next   = r_rr_ptr;
    w_hold_ctr_next = r_hold_ctr;
    w_gnt_next      = r_gnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_idle[IW]) begin
          w_state_next    = ST_GRANT;
          w_owner_next    = w_pick_idle[IW-1:0];
          w_gnt_next      = f_onehot(w_pick_idle[IW-1:0]);
          w_hold_ctr_next = '0;
        end
      end
      ST_GRANT: begin
        if (!w_owner_req || (w_any_other && w_hold_last)) begin
          w_rr_ptr_next   = w_owner_inc;
          w_hold_ctr_next = '0;
          if (w_pick_next[IW]) begin
            w_owner_next = w_pick_next[IW-1:0];
            w_gnt_next   = f_onehot(w_pick_next[IW-1:0]);
          end else begin
            w_state_next = ST_IDLE;
            w_gnt_next   = '0;
          end
        end else if (!w_hold_last) begin
          // Saturates so an uncontested owner yields one cycle after a competitor appears.
          w_hold_ctr_next = r_hold_ctr + 8'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_hold_ctr <= '0;
      r_gnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_hold_ctr <= w_hold_ctr_next;
      r_gnt      <= w_gnt_next;
    end
  end

  assign gnt  = r_gnt;
  assign busy = (r_state == ST_GRANT);

  always_comb begin
    sboxw = 32'h0;
    if (r_state == ST_GRANT) sboxw = w_words[r_owner];
  end

`ifdef AES_SBOX_ARB_PIPE_EN
  logic [31:0]        r_rsp_sboxw;
  logic [NUM_REQ-1:0] r_rsp_valid;

  // Captured with the grant of the presenting cycle, so a handover still answers the old owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_sboxw <= '0;
      r_rsp_valid <= '0;
    end else begin
      r_rsp_sboxw <= new_sboxw;
      r_rsp_valid <= r_gnt & req;
    end
  end

  assign rsp_sboxw = r_rsp_sboxw;
  assign rsp_valid = r_rsp_valid;
`else
  assign rsp_sboxw = busy ? new_sboxw : 32'h0;
  assign rsp_valid = r_gnt & req;
`endif

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Directed bench for aes_sbox_arbiter with a real AES S-box on the lookup port and a
// transaction-level grant model compared every cycle (handles AES_SBOX_ARB_PIPE_EN too).
module tb_aes_sbox_arbiter;
  localparam int N  = 3;
  localparam int MH = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [32*N-1:0] req_sboxw = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     sboxw;
  logic [31:0]     new_sboxw;
  logic [31:0]     rsp_sboxw;
  logic            busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tab [256];

  // Model state: owner index (-1 = none), cycles owned, rotation pointer, pipelined response.
  int          m_owner = -1;
  int          m_held  = 0;
  int          m_ptr   = 0;
  logic [N-1:0] m_pv   = '0;
  logic [31:0]  m_pw   = '0;

  aes_sbox_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_sboxw (req_sboxw),
    .gnt       (gnt),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .rsp_sboxw (rsp_sboxw),
    .rsp_valid (rsp_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                      sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv, b;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]};
    return b ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  function automatic int first_from(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] cur_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  function automatic logic [31:0] cur_word();
    if (m_owner < 0) return 32'h0;
    return req_sboxw[32*m_owner +: 32];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Arbitration rules at transaction level: grant first requester in rotation, yield after
  // MH owned cycles when contested, rotation restarts after the old owner on every change.
  always @(posedge clk or negedge reset_n) begin : model
    int o, h, p;
    logic [N-1:0] oth;
    if (!reset_n) begin
      m_owner <= -1; m_held <= 0; m_ptr <= 0; m_pv <= '0; m_pw <= '0;
    end else begin
      o = m_owner; h = m_held; p = m_ptr;
      m_pv <= cur_gnt() & req;
      m_pw <= sub_word(cur_word());
      if (o < 0) begin
        if (req != '0) begin
          o = first_from(req, p);
          h = 0;
        end
      end else begin
        oth = req;
        oth[o] = 1'b0;
        if (!req[o] || (oth != '0 && h >= MH - 1)) begin
          p = (o + 1) % N;
          h = 0;
          o = (oth != '0) ? first_from(oth, p) : -1;
        end else begin
          h = h + 1;
        end
      end
      m_owner <= o; m_held <= h; m_ptr <= p;
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] eg, ev;
    logic [31:0]  ew;
    if (reset_n) begin
      eg = cur_gnt();
`ifdef AES_SBOX_ARB_PIPE_EN
      ev = m_pv;
      ew = m_pw;
`else
      ev = eg & req;
      ew = sub_word(cur_word());
`endif
      chk("gnt", 32'(gnt), 32'(eg));
      chk("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("sboxw", sboxw, cur_word());
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev != '0) chk("rsp_sboxw", rsp_sboxw, ew);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    req     = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    chk("sbox_00", 32'(sbox_tab[8'h00]), 32'h63);
    chk("sbox_53", 32'(sbox_tab[8'h53]), 32'hed);
    chk("subword", sub_word(32'h00112233), 32'h638293c3);

    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sboxw", sboxw, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_sboxw", rsp_sboxw, 32'h0);
    reset_n = 1'b1;

    // Single requester, then release to idle.
    req_sboxw[31:0] = 32'h00112233;
    req = 3'b001;
    tick(); #1;
    chk("s1_gnt", 32'(gnt), 32'h1);
    chk("s1_sboxw", sboxw, 32'h00112233);
`ifdef AES_SBOX_ARB_PIPE_EN
    chk("s1_valid_lag", 32'(rsp_valid), 32'h0);
    tick(); #1;
`endif
    chk("s1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("s1_rsp_sboxw", rsp_sboxw, 32'h638293c3);
    req = 3'b000; #1;
    chk("s1_drop_gnt", 32'(gnt), 32'h1);
`ifdef AES_SBOX_ARB_PIPE_EN
    chk("s1_drop_valid", 32'(rsp_valid), 32'h1);
`else
    chk("s1_drop_valid", 32'(rsp_valid), 32'h0);
`endif
    tick(); #1;
    chk("s1_idle_gnt", 32'(gnt), 32'h0);
    chk("s1_idle_busy", 32'(busy), 32'h0);
    chk("s1_idle_sboxw", sboxw, 32'h0);
    chk("s1_idle_valid", 32'(rsp_valid), 32'h0);

    // Simultaneous requests from reset: order 0,1,2 then rotation back at 0.
    reset_pulse();
    req_sboxw = {32'hdeadbeef, 32'ha0b0c0d0, 32'h01020304};
    req = 3'b111;
    tick(); #1;  chk("s2_g0", 32'(gnt), 32'h1);
    req = 3'b110;
    tick(); #1;  chk("s2_g1", 32'(gnt), 32'h2); chk("s2_w1", sboxw, 32'ha0b0c0d0);
    req = 3'b100;
    tick(); #1;  chk("s2_g2", 32'(gnt), 32'h4); chk("s2_w2", sboxw, 32'hdeadbeef);
    req = 3'b000;
    tick(); #1;  chk("s2_idle", 32'(gnt), 32'h0);
    req = 3'b011;
    tick(); #1;  chk("s2_again0", 32'(gnt), 32'h1);
    req = 3'b000;
    tick();

    // Starvation bound with MH=4: gnt0 cycles 1-4, gnt1 cycle 5.
    reset_pulse();
    req = 3'b001;
    tick(); #1;  chk("s3_c1", 32'(gnt), 32'h1);
    req = 3'b011;
    #1;          chk("s3_c2pre", 32'(gnt), 32'h1);
    tick(); #1;  chk("s3_c2", 32'(gnt), 32'h1);
    tick(); #1;  chk("s3_c3", 32'(gnt), 32'h1);
    tick(); #1;  chk("s3_c4", 32'(gnt), 32'h1);
    tick(); #1;  chk("s3_c5", 32'(gnt), 32'h2);
    req = 3'b001;
    tick(); #1;  chk("s3_regrant0", 32'(gnt), 32'h1);
    req = 3'b100;
    tick(); #1;  chk("s3_swap", 32'(gnt), 32'h4);
    req = 3'b000;
    tick(); #1;  chk("s3_idle", 32'(gnt), 32'h0);

    // Asynchronous reset in the middle of a grant to requester 1.
    reset_pulse();
    req = 3'b010;
    tick(); #1;  chk("s4_g1", 32'(gnt), 32'h2);
    #1;
    reset_n = 1'b0;
    #1;
    chk("s4_rst_gnt", 32'(gnt), 32'h0);
    chk("s4_rst_busy", 32'(busy), 32'h0);
    chk("s4_rst_sboxw", sboxw, 32'h0);
    chk("s4_rst_valid", 32'(rsp_valid), 32'h0);
    chk("s4_rst_rsp", rsp_sboxw, 32'h0);
    req = 3'b110;
    tick();
    tick();
    reset_n = 1'b1;
    tick(); #1;  chk("s4_after", 32'(gnt), 32'h2);
    req = 3'b000;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
